// File: rtl/dm_axi_master.sv
// dm_axi_master: AXI4 master bridge turning one core request into an AR/R or AW/W/B transaction
module dm_axi_master #(
    parameter logic [3:0] MASTER_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_len,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_data,
    input  logic [3:0]  wd_strb,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic        done,
    output logic        err,
    output logic [3:0]  ARID_M,
    output logic [31:0] ARADDR_M,
    output logic [3:0]  ARLEN_M,
    output logic [2:0]  ARSIZE_M,
    output logic [1:0]  ARBURST_M,
    output logic        ARVALID_M,
    input  logic        ARREADY_M,
    input  logic [3:0]  RID_M,
    input  logic [31:0] RDATA_M,
    input  logic [1:0]  RRESP_M,
    input  logic        RLAST_M,
    input  logic        RVALID_M,
    output logic        RREADY_M,
    output logic [3:0]  AWID_M,
    output logic [31:0] AWADDR_M,
    output logic [3:0]  AWLEN_M,
    output logic [2:0]  AWSIZE_M,
    output logic [1:0]  AWBURST_M,
    output logic        AWVALID_M,
    input  logic        AWREADY_M,
    output logic [31:0] WDATA_M,
    output logic [3:0]  WSTRB_M,
    output logic        WLAST_M,
    output logic        WVALID_M,
    input  logic        WREADY_M,
    input  logic [3:0]  BID_M,
    input  logic [1:0]  BRESP_M,
    input  logic        BVALID_M,
    output logic        BREADY_M
);
    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;
    state_t state, nxt;
    logic [31:0] addr_q;
    logic [3:0]  len_q, cnt;
    logic        err_q, done_q;
    logic        last_cnt, r_beat, r_end, r_bad, w_beat, w_end, b_hs, b_bad;

    assign last_cnt = cnt == len_q;
    assign r_beat   = state == R && RVALID_M && rd_ready;
    assign r_end    = r_beat && (RLAST_M || last_cnt);
    assign r_bad    = RRESP_M != 2'b00 || RID_M != MASTER_ID || RLAST_M != last_cnt;
    assign w_beat   = state == W && wd_valid && WREADY_M;
    assign w_end    = w_beat && last_cnt;
    assign b_hs     = state == B && BVALID_M;
    assign b_bad    = BRESP_M != 2'b00 || BID_M != MASTER_ID;

    assign req_ready = state == IDLE;
    assign ARVALID_M = state == AR;
    assign ARID_M    = ARVALID_M ? MASTER_ID : 4'd0;
    assign ARADDR_M  = addr_q;
    assign ARLEN_M   = len_q;
    assign ARSIZE_M  = ARVALID_M ? 3'b010 : 3'b000;
    assign ARBURST_M = ARVALID_M ? 2'b01 : 2'b00;
    assign AWVALID_M = state == AW;
    assign AWID_M    = AWVALID_M ? MASTER_ID : 4'd0;
    assign AWADDR_M  = addr_q;
    assign AWLEN_M   = len_q;
    assign AWSIZE_M  = AWVALID_M ? 3'b010 : 3'b000;
    assign AWBURST_M = AWVALID_M ? 2'b01 : 2'b00;
    assign RREADY_M  = state == R && rd_ready;
    assign rd_valid  = state == R && RVALID_M;
    assign rd_data   = state == R ? RDATA_M : 32'd0;
    assign rd_last   = state == R && RLAST_M;
    assign WVALID_M  = state == W && wd_valid;
    assign wd_ready  = state == W && WREADY_M;
    assign WDATA_M   = state == W ? wd_data : 32'd0;
    assign WSTRB_M   = state == W ? wd_strb : 4'd0;
    assign WLAST_M   = state == W && last_cnt;
    assign BREADY_M  = state == B;
    assign done      = done_q;
    assign err       = done_q && err_q;

    // next-state selection; an early RLAST or a full-length read ends the burst
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = req_valid ? (req_write ? AW : AR) : IDLE;
            AR:      nxt = ARREADY_M ? R : AR;
            R:       nxt = r_end ? IDLE : R;
            AW:      nxt = AWREADY_M ? W : AW;
            W:       nxt = w_end ? B : W;
            B:       nxt = BVALID_M ? IDLE : B;
            default: nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // request capture, beat counter, sticky error and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= 32'd0;
            len_q  <= 4'd0;
            cnt    <= 4'd0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= r_end || b_hs;
            if (state == IDLE && req_valid) begin
                addr_q <= req_addr;
                len_q  <= req_len;
                err_q  <= 1'b0;
            end
            if ((state == AR && ARREADY_M) || (state == AW && AWREADY_M)) cnt <= 4'd0;
            else if ((r_beat && !r_end) || (w_beat && !w_end)) cnt <= cnt + 4'd1;
            if ((r_beat && r_bad) || (b_hs && b_bad)) err_q <= 1'b1;
        end
    end
endmodule
